id_ex_shift_stage: RTL and testbench
====================================

Name: id_ex_shift_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage that feeds the EX-stage shifter/ALU.
- Each cycle it captures a decoded instruction and its register operands.
- It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the shifter's in, shift_amt and opcode inputs.
- It supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DATA_W, 16, datapath width. Must match the shifter input width.
- REG_W, 4, register-specifier width (16 architectural registers).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hold the ID/EX register contents
- flush  input  1  replace the ID/EX contents with a bubble
- id_valid  input  1  ID slot holds a real instruction
- id_rs  input  REG_W  source A specifier
- id_rt  input  REG_W  source B specifier
- id_rd  input  REG_W  destination specifier
- id_rs_data  input  DATA_W  register-file read A
- id_rt_data  input  DATA_W  register-file read B
- id_imm  input  4  immediate shift amount
- id_is_shift  input  1  instruction is a shift/rotate
- id_shift_op  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRL
- id_reg_write  input  1  instruction writes id_rd
- exm_reg_write  input  1  EX/MEM writes a register
- exm_rd  input  REG_W  EX/MEM destination specifier
- exm_result  input  DATA_W  EX/MEM result
- mwb_reg_write  input  1  MEM/WB writes a register
- mwb_rd  input  REG_W  MEM/WB destination specifier
- mwb_result  input  DATA_W  MEM/WB result
- shift_in  output  DATA_W  forwarded operand A, to shifter in
- shift_amt  output  4  to shifter shift_amt
- shift_opcode  output  2  to shifter opcode
- ex_opb  output  DATA_W  forwarded operand B
- ex_valid  output  1  EX slot holds a real instruction
- ex_is_shift  output  1  registered id_is_shift
- ex_rd  output  REG_W  registered destination
- ex_reg_write  output  1  registered write enable, gated by valid
- fwd_a_sel  output  2  00 register, 01 MEM/WB, 10 EX/MEM (debug/verification)
- fwd_b_sel  output  2  same encoding, for operand B

Behaviour:
- Reset (asynchronous, active-high): all ID/EX register fields clear to 0. Outputs are then ex_valid=0, ex_reg_write=0, ex_is_shift=0, ex_rd=0, shift_amt=0, shift_opcode=0, shift_in=0, ex_opb=0, fwd_*_sel=00.
- Latency: ID inputs appear on the EX outputs one clk after capture.
- Priority per rising edge: flush > stall > normal load.
  - flush=1: valid, reg_write and is_shift clear to 0; data fields don't-care (implementation clears them to 0). Flush overrides a simultaneous stall.
  - stall=1, flush=0: all fields hold, except operand A/B data. These are rewritten with the currently forwarded values, so a producer that leaves MEM/WB during the stall is not lost.
  - Normal: all fields load from id_*. ex_reg_write loads id_reg_write & id_valid.
- Forwarding (combinational off the registered rs/rt), evaluated independently for A and B:
  - Select EX/MEM if exm_reg_write=1, exm_rd==src and src!=0.
  - Else select MEM/WB if mwb_reg_write=1, mwb_rd==src and src!=0.
  - Else use the registered data.
  - EX/MEM beats MEM/WB when both match. R0 is never forwarded; it always reads the registered value.
- Shifter drive:
  - shift_in = forwarded A.
  - shift_amt = registered imm when ex_is_shift=1, else 0.
  - shift_opcode = registered op.
  - With ex_valid=0 all three still follow the registers; downstream gating on ex_valid is mandatory.
- Reset mid-stall: reset wins immediately, asynchronously; no held state survives.
- No internal state beyond the ID/EX register. The forwarding muxes are combinational and contain no latches.

Test Plan:
- Reset then idle: assert rst with id_valid=1 present -> all outputs 0. After release and one clk with id_valid=1, id_is_shift=1, id_imm=4'h3, id_shift_op=01, id_rs_data=16'h0011 -> shift_in=16'h0011, shift_amt=3, shift_opcode=01, ex_valid=1.
- EX/MEM vs MEM/WB priority: registered rs=5; exm_reg_write=1, exm_rd=5, exm_result=16'hAAAA; mwb_reg_write=1, mwb_rd=5, mwb_result=16'h5555 -> shift_in=16'hAAAA, fwd_a_sel=10. Drop exm_reg_write -> shift_in=16'h5555, fwd_a_sel=01.
- R0 guard: rs=0, rs_data=16'h0000, exm_rd=0, exm_reg_write=1, exm_result=16'hFFFF -> shift_in=16'h0000, fwd_a_sel=00.
- Stall capture: rt=7, rt_data=16'h1234; mwb forwards 16'hBEEF on cycle N with stall=1. On cycle N+1 mwb_rd=3 and stall=1 -> ex_opb stays 16'hBEEF with fwd_b_sel=00. Other fields unchanged.
- Flush vs stall: stall=1 and flush=1 on the same edge with a valid writing instruction held -> next cycle ex_valid=0, ex_reg_write=0, ex_is_shift=0, shift_amt=0.
- Async reset mid-operation: rst pulsed between clock edges while ex_valid=1 -> outputs clear before the next edge. The first post-reset edge loads the new ID instruction normally.

Source files
------------

// File: rtl/id_ex_shift_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Ports: ID-side decode + operands in, EX/MEM and MEM/WB producers in,
//   shifter drive (shift_in/amt/opcode), operand B, EX control and fwd selects out.
module id_ex_shift_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [3:0]        id_imm,
  input  logic              id_is_shift,
  input  logic [1:0]        id_shift_op,
  input  logic              id_reg_write,
  input  logic              exm_reg_write,
  input  logic [REG_W-1:0]  exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_W-1:0]  mwb_rd,
  input  logic [DATA_W-1:0] mwb_result,
  output logic [DATA_W-1:0] shift_in,
  output logic [3:0]        shift_amt,
  output logic [1:0]        shift_opcode,
  output logic [DATA_W-1:0] ex_opb,
  output logic              ex_valid,
  output logic              ex_is_shift,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_reg_write,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel
);

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MWB = 2'b01;
  localparam logic [1:0] FWD_EXM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              is_shift;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        imm;
    logic [1:0]        op;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t ex_d;

  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;

  // R0 is hardwired zero, so a write to it never forwards.
  always_comb begin
    sel_a = FWD_REG;
    if (ex_q.rs != '0) begin
      if (exm_reg_write && exm_rd == ex_q.rs)
        sel_a = FWD_EXM;
      else if (mwb_reg_write && mwb_rd == ex_q.rs)
        sel_a = FWD_MWB;
    end
  end

  always_comb begin
    sel_b = FWD_REG;
    if (ex_q.rt != '0) begin
      if (exm_reg_write && exm_rd == ex_q.rt)
        sel_b = FWD_EXM;
      else if (mwb_reg_write && mwb_rd == ex_q.rt)
        sel_b = FWD_MWB;
    end
  end

  always_comb begin
    opa = ex_q.a;
    unique case (sel_a)
      FWD_EXM: opa = exm_result;
      FWD_MWB: opa = mwb_result;
      default: opa = ex_q.a;
    endcase
  end

  always_comb begin
    opb = ex_q.b;
    unique case (sel_b)
      FWD_EXM: opb = exm_result;
      FWD_MWB: opb = mwb_result;
      default: opb = ex_q.b;
    endcase
  end

  // While stalled the operands are refreshed with the forwarded
  // values so a producer retiring out of MEM/WB is not lost.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      ex_d.a = opa;
      ex_d.b = opb;
    end else begin
      ex_d.valid     = id_valid;
      ex_d.reg_write = id_reg_write & id_valid;
      ex_d.is_shift  = id_is_shift;
      ex_d.rs        = id_rs;
      ex_d.rt        = id_rt;
      ex_d.rd        = id_rd;
      ex_d.a         = id_rs_data;
      ex_d.b         = id_rt_data;
      ex_d.imm       = id_imm;
      ex_d.op        = id_shift_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign shift_in     = opa;
  assign shift_amt    = ex_q.is_shift ? ex_q.imm : 4'd0;
  assign shift_opcode = ex_q.op;
  assign ex_opb       = opb;
  assign ex_valid     = ex_q.valid;
  assign ex_is_shift  = ex_q.is_shift;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.reg_write;
  assign fwd_a_sel    = sel_a;
  assign fwd_b_sel    = sel_b;

endmodule

// File: tb/tb_id_ex_shift_stage.sv
// Bench for id_ex_shift_stage: directed cases plus random
// stimulus checked against a behavioural slot model.
module tb_id_ex_shift_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        id_valid;
  logic [3:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_rs_data, id_rt_data;
  logic [3:0]  id_imm;
  logic        id_is_shift;
  logic [1:0]  id_shift_op;
  logic        id_reg_write;
  logic        exm_reg_write;
  logic [3:0]  exm_rd;
  logic [15:0] exm_result;
  logic        mwb_reg_write;
  logic [3:0]  mwb_rd;
  logic [15:0] mwb_result;
  logic [15:0] shift_in;
  logic [3:0]  shift_amt;
  logic [1:0]  shift_opcode;
  logic [15:0] ex_opb;
  logic        ex_valid;
  logic        ex_is_shift;
  logic [3:0]  ex_rd;
  logic        ex_reg_write;
  logic [1:0]  fwd_a_sel, fwd_b_sel;

  always #5 clk = ~clk;

  id_ex_shift_stage #(.DATA_W(16), .REG_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_is_shift(id_is_shift),
    .id_shift_op(id_shift_op), .id_reg_write(id_reg_write),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
    .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
    .mwb_result(mwb_result),
    .shift_in(shift_in), .shift_amt(shift_amt),
    .shift_opcode(shift_opcode), .ex_opb(ex_opb),
    .ex_valid(ex_valid), .ex_is_shift(ex_is_shift),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model of the instruction sitting in EX.
  logic        m_valid, m_rw, m_sh;
  logic [3:0]  m_rs, m_rt, m_rd, m_imm;
  logic [15:0] m_a, m_b;
  logic [1:0]  m_op;

  function automatic logic [1:0] ref_sel(input logic [3:0] src);
    if (src == 4'd0) return 2'b00;
    if (exm_reg_write && exm_rd == src) return 2'b10;
    if (mwb_reg_write && mwb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [15:0] ref_val(input logic [3:0] src,
                                          input logic [15:0] held);
    case (ref_sel(src))
      2'b10:   return exm_result;
      2'b01:   return mwb_result;
      default: return held;
    endcase
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_sh = 0;
    m_rs = 0; m_rt = 0; m_rd = 0; m_imm = 0;
    m_a = 0; m_b = 0; m_op = 0;
  endtask

  task automatic model_update();
    logic [15:0] fa, fb;
    fa = ref_val(m_rs, m_a);
    fb = ref_val(m_rt, m_b);
    if (rst || flush) begin
      model_clear();
    end else if (stall) begin
      m_a = fa;
      m_b = fb;
    end else begin
      m_valid = id_valid;
      m_rw    = id_valid && id_reg_write;
      m_sh    = id_is_shift;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      m_a = id_rs_data; m_b = id_rt_data;
      m_imm = id_imm; m_op = id_shift_op;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic check_all(input string p);
    chk({p, "_in"},  shift_in, ref_val(m_rs, m_a));
    chk({p, "_amt"}, 16'(shift_amt), m_sh ? 16'(m_imm) : 16'd0);
    chk({p, "_op"},  16'(shift_opcode), 16'(m_op));
    chk({p, "_opb"}, ex_opb, ref_val(m_rt, m_b));
    chk({p, "_vld"}, 16'(ex_valid), 16'(m_valid));
    chk({p, "_sh"},  16'(ex_is_shift), 16'(m_sh));
    chk({p, "_rd"},  16'(ex_rd), 16'(m_rd));
    chk({p, "_rw"},  16'(ex_reg_write), 16'(m_rw));
    chk({p, "_sa"},  16'(fwd_a_sel), 16'(ref_sel(m_rs)));
    chk({p, "_sb"},  16'(fwd_b_sel), 16'(ref_sel(m_rt)));
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_is_shift = 0; id_shift_op = 0; id_reg_write = 0;
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
  endtask

  task automatic randomize_inputs();
    stall = ($urandom_range(0, 3) == 0);
    flush = ($urandom_range(0, 7) == 0);
    id_valid = 1'($urandom);
    id_rs = 4'($urandom_range(0, 3));
    id_rt = 4'($urandom_range(0, 3));
    id_rd = 4'($urandom);
    id_rs_data = 16'($urandom);
    id_rt_data = 16'($urandom);
    id_imm = 4'($urandom);
    id_is_shift = 1'($urandom);
    id_shift_op = 2'($urandom);
    id_reg_write = 1'($urandom);
    exm_reg_write = 1'($urandom);
    exm_rd = 4'($urandom_range(0, 3));
    exm_result = 16'($urandom);
    mwb_reg_write = 1'($urandom);
    mwb_rd = 4'($urandom_range(0, 3));
    mwb_result = 16'($urandom);
  endtask

  initial begin
    idle_inputs();
    model_clear();
    rst = 1;
    id_valid = 1; id_reg_write = 1; id_is_shift = 1;
    id_imm = 4'h9; id_rs_data = 16'hDEAD;
    repeat (2) tick();
    #1;
    check_all("rst");
    chk("rst_vld", 16'(ex_valid), 16'd0);

    // First instruction after reset.
    rst = 0;
    idle_inputs();
    id_valid = 1; id_is_shift = 1; id_imm = 4'h3;
    id_shift_op = 2'b01; id_rs = 4'd1; id_rs_data = 16'h0011;
    tick();
    chk("t1_in", shift_in, 16'h0011);
    chk("t1_amt", 16'(shift_amt), 16'd3);
    chk("t1_op", 16'(shift_opcode), 16'd1);
    chk("t1_vld", 16'(ex_valid), 16'd1);
    check_all("t1");

    // EX/MEM beats MEM/WB.
    idle_inputs();
    id_valid = 1; id_rs = 4'd5; id_rs_data = 16'h1234;
    tick();
    exm_reg_write = 1; exm_rd = 4'd5; exm_result = 16'hAAAA;
    mwb_reg_write = 1; mwb_rd = 4'd5; mwb_result = 16'h5555;
    #1;
    chk("pri_in", shift_in, 16'hAAAA);
    chk("pri_sel", 16'(fwd_a_sel), 16'd2);
    exm_reg_write = 0;
    #1;
    chk("mwb_in", shift_in, 16'h5555);
    chk("mwb_sel", 16'(fwd_a_sel), 16'd1);
    check_all("mwb");

    // R0 guard.
    idle_inputs();
    id_valid = 1; id_rs = 4'd0; id_rs_data = 16'h0000;
    tick();
    exm_reg_write = 1; exm_rd = 4'd0; exm_result = 16'hFFFF;
    #1;
    chk("r0_in", shift_in, 16'h0000);
    chk("r0_sel", 16'(fwd_a_sel), 16'd0);

    // Stall captures a MEM/WB value before it leaves.
    idle_inputs();
    id_valid = 1; id_reg_write = 1; id_rd = 4'd9;
    id_rt = 4'd7; id_rt_data = 16'h1234;
    tick();
    idle_inputs();
    stall = 1; mwb_reg_write = 1; mwb_rd = 4'd7;
    mwb_result = 16'hBEEF;
    tick();
    mwb_rd = 4'd3;
    #1;
    chk("stl_opb", ex_opb, 16'hBEEF);
    chk("stl_sb", 16'(fwd_b_sel), 16'd0);
    chk("stl_rd", 16'(ex_rd), 16'd9);
    chk("stl_rw", 16'(ex_reg_write), 16'd1);
    tick();
    check_all("stl");

    // Flush wins over stall.
    idle_inputs();
    id_valid = 1; id_reg_write = 1; id_is_shift = 1; id_imm = 4'h5;
    tick();
    stall = 1; flush = 1;
    tick();
    chk("fl_vld", 16'(ex_valid), 16'd0);
    chk("fl_rw", 16'(ex_reg_write), 16'd0);
    chk("fl_sh", 16'(ex_is_shift), 16'd0);
    chk("fl_amt", 16'(shift_amt), 16'd0);

    // Asynchronous reset between edges.
    idle_inputs();
    id_valid = 1; id_reg_write = 1; id_is_shift = 1; id_imm = 4'h7;
    id_rs = 4'd2; id_rs_data = 16'h4321;
    tick();
    chk("ar_pre", 16'(ex_valid), 16'd1);
    #1 rst = 1;
    #1;
    model_clear();
    chk("ar_vld", 16'(ex_valid), 16'd0);
    chk("ar_in", shift_in, 16'h0000);
    check_all("ar");
    rst = 0;
    id_imm = 4'h2; id_rs_data = 16'h00F0;
    tick();
    chk("ar_ld_in", shift_in, 16'h00F0);
    chk("ar_ld_amt", 16'(shift_amt), 16'd2);
    check_all("ar_ld");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      #1;
      check_all("rnd");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
